// File: rtl/noc_pkg.sv
// Shared NoC definitions for the transmit arbiter: bus-width derivation,
// header field offsets and the arbiter state encoding.
package noc_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int HDR_CTRL_BITS = 6;

   function automatic int soc_xy_size(input int size_x, input int size_y);
      return 2 * size_x + 2 * size_y;
   endfunction

   function automatic int noc_bus_size(input int data_w, input int size_x, input int size_y);
      return data_w + soc_xy_size(size_x, size_y) + HDR_CTRL_BITS;
   endfunction

   // Header layout above the payload: destination/source coordinates, then control bits.
   function automatic int hdr_xy_offset(input int data_w);
      return data_w;
   endfunction

   function automatic int hdr_ctrl_offset(input int data_w, input int size_x, input int size_y);
      return data_w + soc_xy_size(size_x, size_y);
   endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational find-first-set over a request vector, starting at a rotating
// pointer and wrapping modulo NUM_REQ.
module rr_prio_select #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_REQ_LOG2 = 2
) (
   input  logic [NUM_REQ-1:0]      req_i,
   input  logic [NUM_REQ_LOG2-1:0] ptr_i,
   output logic [NUM_REQ-1:0]      grant_o,
   output logic [NUM_REQ_LOG2-1:0] idx_o,
   output logic                    any_o
);

   always_comb begin : find_first
      int k;
      k       = 0;
      idx_o   = '0;
      any_o   = 1'b0;
      grant_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = int'(ptr_i) + i;
         if (k >= NUM_REQ) begin
            k = k - NUM_REQ;
         end
         if (!any_o && req_i[k]) begin
            any_o = 1'b1;
            idx_o = NUM_REQ_LOG2'(k);
         end
      end
      if (any_o) begin
         grant_o = NUM_REQ'(1) << idx_o;
      end
   end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Round-robin arbiter sharing one router injection port between NUM_REQ
// requesters; a grant lasts until the owner drops wr or MAX_BURST flits pass.
module noc_tx_arbiter
   import noc_pkg::*;
#(
   parameter int NOC_DATA_WIDTH = 56,
   parameter int SOC_SIZE_X     = 1,
   parameter int SOC_SIZE_Y     = 1,
   parameter int NUM_REQ        = 4,
   parameter int NUM_REQ_LOG2   = 2,
   parameter int MAX_BURST      = 8,
   parameter int MAX_BURST_LOG2 = 3,
   localparam int NOC_BUS_SIZE  = noc_bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_REQ*NOC_BUS_SIZE-1:0] req_din_i,
   input  logic [NUM_REQ-1:0]              req_wr_i,
   output logic [NUM_REQ-1:0]              req_wait_o,
   output logic [NOC_BUS_SIZE-1:0]         noc_din_o,
   output logic                            noc_wr_o,
   input  logic                            noc_wait_i,
   output logic [NUM_REQ-1:0]              grant_o,
   output logic                            busy_o
);

   localparam logic [NUM_REQ_LOG2-1:0]   LAST_IDX  = NUM_REQ_LOG2'(NUM_REQ - 1);
   localparam logic [MAX_BURST_LOG2-1:0] LAST_BEAT = MAX_BURST_LOG2'(MAX_BURST - 1);

   arb_state_e                state_q, state_d;
   logic [NUM_REQ-1:0]        grant_q, grant_d;
   logic [NUM_REQ_LOG2-1:0]   gidx_q, gidx_d;
   logic [NUM_REQ_LOG2-1:0]   ptr_q, ptr_d;
   logic [MAX_BURST_LOG2-1:0] cnt_q, cnt_d;

   logic [NUM_REQ-1:0]        sel_grant;
   logic [NUM_REQ_LOG2-1:0]   sel_idx;
   logic                      sel_any;
   logic                      burst_done;

   rr_prio_select #(
      .NUM_REQ      (NUM_REQ),
      .NUM_REQ_LOG2 (NUM_REQ_LOG2)
   ) u_sel (
      .req_i   (req_wr_i),
      .ptr_i   (ptr_q),
      .grant_o (sel_grant),
      .idx_o   (sel_idx),
      .any_o   (sel_any)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are driven straight from the registered grant so a reset clears them at once.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      burst_done = 1'b0;
      noc_din_o  = '0;
      noc_wr_o   = 1'b0;
      req_wait_o = '1;
      busy_o     = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_any) begin
               state_d = GRANT;
               grant_d = sel_grant;
               gidx_d  = sel_idx;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            busy_o             = 1'b1;
            noc_din_o          = req_din_i[gidx_q*NOC_BUS_SIZE +: NOC_BUS_SIZE];
            noc_wr_o           = req_wr_i[gidx_q];
            req_wait_o[gidx_q] = noc_wait_i;
            if (!req_wr_i[gidx_q]) begin
               burst_done = 1'b1;
            end else if (!noc_wait_i) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d      = '0;
                  burst_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + MAX_BURST_LOG2'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
            if (burst_done) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + NUM_REQ_LOG2'(1);
            end else begin
               state_d = GRANT;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign grant_o = grant_q;

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Directed scoreboard bench for noc_tx_arbiter: requester queues feed flits,
// expected (grant, flit) pairs are queued at stimulus time and popped on transfer.
module tb_noc_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int BUS     = 56 + 2 + 2 + 6;
   localparam int DEPTH   = 128;

   typedef struct packed {
      logic [NUM_REQ-1:0] gnt;
      logic [BUS-1:0]     din;
   } exp_t;

   logic                   clk;
   logic                   rst;
   logic [NUM_REQ*BUS-1:0] req_din;
   logic [NUM_REQ-1:0]     req_wr;
   logic [NUM_REQ-1:0]     req_wait_o;
   logic [BUS-1:0]         noc_din_o;
   logic                   noc_wr_o;
   logic                   noc_wait;
   logic [NUM_REQ-1:0]     grant_o;
   logic                   busy_o;

   exp_t                   sb[$];
   logic [BUS-1:0]         src_mem [NUM_REQ][DEPTH];
   int                     src_head [NUM_REQ];
   int                     src_tail [NUM_REQ];
   logic [NUM_REQ-1:0]     taken;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int xfer_cnt = 0;
   int first_x  = -1;
   int last_x   = -1;

   noc_tx_arbiter dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_din_i  (req_din),
      .req_wr_i   (req_wr),
      .req_wait_o (req_wait_o),
      .noc_din_o  (noc_din_o),
      .noc_wr_o   (noc_wr_o),
      .noc_wait_i (noc_wait),
      .grant_o    (grant_o),
      .busy_o     (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks = n_checks + 1;
      assert (got === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int k, input logic [BUS-1:0] v);
      exp_t e;
      src_mem[k][src_tail[k]] = v;
      src_tail[k] = src_tail[k] + 1;
      e.gnt = NUM_REQ'(1) << k;
      e.din = v;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag, input int limit);
      for (int c = 0; c < limit && sb.size() != 0; c++) @(negedge clk);
      chk({tag, "_drain"}, 128'(sb.size()), 128'(0));
      repeat (2) @(negedge clk);
      chk({tag, "_idle_grant"}, 128'(grant_o), 128'(0));
      chk({tag, "_idle_busy"}, 128'(busy_o), 128'(0));
   endtask

   // Requester model: presents its queue head and advances after each accepted flit.
   initial begin
      taken = '0;
      forever begin
         @(negedge clk);
         taken = req_wr & ~req_wait_o;
      end
   end

   initial begin
      for (int k = 0; k < NUM_REQ; k++) begin
         src_head[k] = 0;
         src_tail[k] = 0;
      end
      req_wr  = '0;
      req_din = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (taken[k]) src_head[k] = src_head[k] + 1;
            req_wr[k] = (src_head[k] < src_tail[k]);
            req_din[k*BUS +: BUS] = req_wr[k] ? src_mem[k][src_head[k]] : '0;
         end
      end
   end

   // Monitor: every accepted router flit must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("grant_onehot0", 128'($onehot0(grant_o)), 128'(1));
            if (noc_wr_o && !noc_wait) begin
               xfer_cnt = xfer_cnt + 1;
               if (first_x < 0) first_x = cyc;
               last_x = cyc;
               if (sb.size() == 0) begin
                  chk("unexpected_flit", 128'(noc_din_o), 128'(0));
               end else begin
                  e = sb.pop_front();
                  chk("flit_data", 128'(noc_din_o), 128'(e.din));
                  chk("flit_grant", 128'(grant_o), 128'(e.gnt));
               end
            end
         end
      end
   end

   initial begin
      int base;
      rst      = 1'b1;
      noc_wait = 1'b0;
      #2;
      chk("rst_wr", 128'(noc_wr_o), 128'(0));
      chk("rst_wait", 128'(req_wait_o), 128'(4'b1111));
      chk("rst_grant", 128'(grant_o), 128'(0));
      chk("rst_busy", 128'(busy_o), 128'(0));
      chk("rst_din", 128'(noc_din_o), 128'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset
      repeat (4) begin
         @(negedge clk);
         chk("idle_wr", 128'(noc_wr_o), 128'(0));
         chk("idle_wait", 128'(req_wait_o), 128'(4'b1111));
         chk("idle_grant", 128'(grant_o), 128'(0));
      end

      // Full contention from pointer 0: 0,1,2,3,0 with 8 flits each and one dead cycle
      first_x = -1;
      for (int k = 0; k < NUM_REQ; k++)
         for (int i = 0; i < 8; i++) push(k, BUS'(32'h1000 * (k + 1) + i));
      for (int i = 0; i < 8; i++) push(0, BUS'(32'h5000 + i));
      drain("contend", 300);
      chk("contend_span", 128'(last_x - first_x), 128'(43));

      // Single burst from requester 2
      push(2, BUS'(8'hA0));
      push(2, BUS'(8'hA1));
      push(2, BUS'(8'hA2));
      @(negedge clk);
      chk("single_pre_grant", 128'(grant_o), 128'(0));
      @(negedge clk);
      chk("single_grant", 128'(grant_o), 128'(4'b0100));
      chk("single_first", 128'(noc_din_o), 128'(8'hA0));
      drain("single", 50);

      // Pointer is 3: requests on 0 and 1 wrap to 0 first
      for (int i = 0; i < 3; i++) push(0, BUS'(32'h6000 + i));
      for (int i = 0; i < 3; i++) push(1, BUS'(32'h7000 + i));
      drain("wrap", 50);

      // Pointer is 2: requester 3 beats requester 1
      for (int i = 0; i < 2; i++) push(3, BUS'(32'h8300 + i));
      for (int i = 0; i < 2; i++) push(1, BUS'(32'h8100 + i));
      drain("ptr2", 50);

      // Backpressure: 5-cycle stall after two flits of a 9-flit stream
      first_x = -1;
      base    = xfer_cnt;
      for (int i = 0; i < 9; i++) push(1, BUS'(32'h9000 + i));
      for (int c = 0; c < 50 && xfer_cnt < base + 2; c++) begin
         @(posedge clk);
         #1;
      end
      chk("stall_start", 128'(xfer_cnt - base), 128'(2));
      noc_wait = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_wait", 128'(req_wait_o), 128'(4'b1111));
         chk("stall_grant", 128'(grant_o), 128'(4'b0010));
         chk("stall_wr", 128'(noc_wr_o), 128'(1));
         chk("stall_hold", 128'(noc_din_o), 128'(32'h9002));
      end
      @(posedge clk);
      #1;
      noc_wait = 1'b0;
      drain("stall", 80);
      chk("stall_span", 128'(last_x - first_x), 128'(14));

      // Asynchronous reset in the middle of a stalled grant
      noc_wait = 1'b1;
      push(2, BUS'(32'hB000));
      repeat (2) @(negedge clk);
      chk("arst_pre_grant", 128'(grant_o), 128'(4'b0100));
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_wr", 128'(noc_wr_o), 128'(0));
      chk("arst_grant", 128'(grant_o), 128'(0));
      chk("arst_wait", 128'(req_wait_o), 128'(4'b1111));
      for (int k = 0; k < NUM_REQ; k++) src_head[k] = src_tail[k];
      sb.delete();
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      noc_wait = 1'b0;
      for (int i = 0; i < 2; i++) push(1, BUS'(32'hC100 + i));
      for (int i = 0; i < 2; i++) push(3, BUS'(32'hC300 + i));
      drain("arst_ptr0", 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
